// File: rtl/mem_wb_stage_buf.sv
// MEM->WB pipeline buffer: a two-entry skid buffer (main/head + skid) with registered
// ready, strict FIFO order, flush, x0 reg_write squash and a saturating stall counter.
module mem_wb_stage_buf #(
   parameter int DATA_WIDTH    = 64,
   parameter int REG_ID_WIDTH  = 5,
   parameter int WB_CTRL_WIDTH = 2,
   parameter int X0_SQUASH     = 1,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    alu_in,
   input  logic [DATA_WIDTH-1:0]    mem_data_in,
   input  logic [REG_ID_WIDTH-1:0]  dest_in,
   input  logic [WB_CTRL_WIDTH-1:0] wb_control_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    alu_out,
   output logic [DATA_WIDTH-1:0]    mem_data_out,
   output logic [REG_ID_WIDTH-1:0]  dest_out,
   output logic [WB_CTRL_WIDTH-1:0] wb_control_out,
   output logic [CNT_WIDTH-1:0]     stall_cnt,
   output logic [1:0]               state_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]    alu;
      logic [DATA_WIDTH-1:0]    mem;
      logic [REG_ID_WIDTH-1:0]  dest;
      logic [WB_CTRL_WIDTH-1:0] wb;
   } entry_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   // Handshake: a beat moves upstream when in_valid & in_ready (and no flush),
   // downstream when out_valid & out_ready. in_ready depends on state only.
   state_e               state_q;
   entry_t               main_q;
   entry_t               skid_q;
   entry_t               cap_d;
   logic [CNT_WIDTH-1:0] stall_q;
   logic                 accept;
   logic                 issue;

   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid & in_ready & ~flush;
   assign issue     = out_valid & out_ready;

   always_comb begin
      cap_d.alu  = alu_in;
      cap_d.mem  = mem_data_in;
      cap_d.dest = dest_in;
      cap_d.wb   = wb_control_in;
      // Writes to x0 are architecturally discarded, so drop reg_write at capture.
      if (X0_SQUASH != 0 && dest_in == '0) begin
         cap_d.wb[1] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         stall_q <= '0;
      end else begin
         if (out_valid && !out_ready && stall_q != '1) begin
            stall_q <= stall_q + CNT_ONE;
         end
         if (flush) begin
            state_q <= ST_EMPTY;
         end else begin
            case (state_q)
               ST_EMPTY: begin
                  if (accept) begin
                     main_q  <= cap_d;
                     state_q <= ST_ONE;
                  end
               end
               ST_ONE: begin
                  if (accept && !issue) begin
                     skid_q  <= cap_d;
                     state_q <= ST_FULL;
                  end else if (issue && !accept) begin
                     state_q <= ST_EMPTY;
                  end else if (accept && issue) begin
                     main_q <= cap_d;
                  end
               end
               ST_FULL: begin
                  if (issue) begin
                     main_q  <= skid_q;
                     state_q <= ST_ONE;
                  end
               end
               default: state_q <= ST_EMPTY;
            endcase
         end
      end
   end

   assign alu_out        = main_q.alu;
   assign mem_data_out   = main_q.mem;
   assign dest_out       = main_q.dest;
   assign wb_control_out = out_valid ? main_q.wb : '0;
   assign stall_cnt      = stall_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Directed bench for mem_wb_stage_buf: default instance plus X0_SQUASH=0 and
// CNT_WIDTH=4 instances sharing the same stimulus.
module tb_mem_wb_stage_buf;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] alu_in;
   logic [63:0] mem_data_in;
   logic [4:0]  dest_in;
   logic [1:0]  wb_control_in;

   logic        in_ready, out_valid;
   logic [63:0] alu_out, mem_data_out;
   logic [4:0]  dest_out;
   logic [1:0]  wb_control_out;
   logic [15:0] stall_cnt;
   logic [1:0]  state_o;

   logic        ns_in_ready, ns_out_valid;
   logic [63:0] ns_alu_out, ns_mem_data_out;
   logic [4:0]  ns_dest_out;
   logic [1:0]  ns_wb_control_out;
   logic [15:0] ns_stall_cnt;
   logic [1:0]  ns_state_o;

   logic        c4_in_ready, c4_out_valid;
   logic [63:0] c4_alu_out, c4_mem_data_out;
   logic [4:0]  c4_dest_out;
   logic [1:0]  c4_wb_control_out;
   logic [3:0]  c4_stall_cnt;
   logic [1:0]  c4_state_o;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   mem_wb_stage_buf dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_in(alu_in), .mem_data_in(mem_data_in), .dest_in(dest_in),
      .wb_control_in(wb_control_in), .out_valid(out_valid), .out_ready(out_ready),
      .alu_out(alu_out), .mem_data_out(mem_data_out), .dest_out(dest_out),
      .wb_control_out(wb_control_out), .stall_cnt(stall_cnt), .state_o(state_o)
   );

   mem_wb_stage_buf #(.X0_SQUASH(0)) dut_ns (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ns_in_ready),
      .alu_in(alu_in), .mem_data_in(mem_data_in), .dest_in(dest_in),
      .wb_control_in(wb_control_in), .out_valid(ns_out_valid), .out_ready(out_ready),
      .alu_out(ns_alu_out), .mem_data_out(ns_mem_data_out), .dest_out(ns_dest_out),
      .wb_control_out(ns_wb_control_out), .stall_cnt(ns_stall_cnt), .state_o(ns_state_o)
   );

   mem_wb_stage_buf #(.CNT_WIDTH(4)) dut_c4 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c4_in_ready),
      .alu_in(alu_in), .mem_data_in(mem_data_in), .dest_in(dest_in),
      .wb_control_in(wb_control_in), .out_valid(c4_out_valid), .out_ready(out_ready),
      .alu_out(c4_alu_out), .mem_data_out(c4_mem_data_out), .dest_out(c4_dest_out),
      .wb_control_out(c4_wb_control_out), .stall_cnt(c4_stall_cnt), .state_o(c4_state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic push(input logic [63:0] a, input logic [4:0] d, input logic [1:0] w);
      in_valid = 1'b1; alu_in = a; mem_data_in = ~a; dest_in = d; wb_control_in = w;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      alu_in = 64'hdead; mem_data_in = 64'hbeef; dest_in = 5'd7; wb_control_in = 2'b11;
      step(); step();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (alu_out !== 64'd0 || mem_data_out !== 64'd0 || dest_out !== 5'd0) begin
         errors++; $display("FAIL reset_payload got %h/%h/%h want 0", alu_out, mem_data_out, dest_out); end
      checks++; if (wb_control_out !== 2'b00) begin errors++; $display("FAIL reset_wb got %b want 00", wb_control_out); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
   endtask

   task automatic test_single();
      do_reset();
      out_ready = 1'b0;
      push(64'h11, 5'd3, 2'b10);
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
      checks++; if (alu_out !== 64'h11) begin errors++; $display("FAIL single_alu got %h want 11", alu_out); end
      checks++; if (mem_data_out !== ~64'h11) begin errors++; $display("FAIL single_mem got %h want %h", mem_data_out, ~64'h11); end
      checks++; if (dest_out !== 5'd3) begin errors++; $display("FAIL single_dest got %0d want 3", dest_out); end
      checks++; if (wb_control_out !== 2'b10) begin errors++; $display("FAIL single_wb got %b want 10", wb_control_out); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", out_valid); end
      checks++; if (wb_control_out !== 2'b00) begin errors++; $display("FAIL idle_wb got %b want 00", wb_control_out); end
      checks++; if (alu_out !== 64'h11 || dest_out !== 5'd3) begin
         errors++; $display("FAIL idle_hold got %h/%0d want 11/3", alu_out, dest_out); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL single_stall got %0d want 0", stall_cnt); end
   endtask

   task automatic test_full_order();
      do_reset();
      out_ready = 1'b0;
      push(64'hA, 5'd1, 2'b10); step();
      push(64'hB, 5'd2, 2'b10); step();
      checks++; if (in_ready !== 1'b0 || state_o !== 2'd2) begin
         errors++; $display("FAIL full_state got ready=%b state=%0d want 0/2", in_ready, state_o); end
      checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL full_stall1 got %0d want 1", stall_cnt); end
      push(64'hC, 5'd3, 2'b10); step();
      checks++; if (alu_out !== 64'hA || stall_cnt !== 16'd2) begin
         errors++; $display("FAIL full_hold got alu=%h stall=%0d want a/2", alu_out, stall_cnt); end
      out_ready = 1'b1; step();
      checks++; if (alu_out !== 64'hB || dest_out !== 5'd2 || in_ready !== 1'b1) begin
         errors++; $display("FAIL order_b got alu=%h dest=%0d ready=%b want b/2/1", alu_out, dest_out, in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (alu_out !== 64'hC || dest_out !== 5'd3 || out_valid !== 1'b1) begin
         errors++; $display("FAIL order_c got alu=%h dest=%0d valid=%b want c/3/1", alu_out, dest_out, out_valid); end
      step();
      checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd2) begin
         errors++; $display("FAIL order_end got valid=%b stall=%0d want 0/2", out_valid, stall_cnt); end
   endtask

   task automatic test_back_to_back();
      int transfers;
      logic [63:0] got;
      do_reset();
      exp_q.delete();
      transfers = 0;
      out_ready = 1'b1;
      for (int c = 0; c <= 100; c++) begin
         if (c < 100) push(64'h100 + 64'(c), 5'(c % 31 + 1), 2'b10);
         else in_valid = 1'b0;
         if (out_valid && out_ready) begin
            transfers++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL stream_extra got %h want none", alu_out);
            end else begin
               got = exp_q.pop_front();
               if (alu_out !== got) begin errors++; $display("FAIL stream_order got %h want %h", alu_out, got); end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(alu_in);
         step();
      end
      checks++; if (transfers !== 100) begin errors++; $display("FAIL stream_count got %0d want 100", transfers); end
      checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         errors++; $display("FAIL stream_drain got valid=%b left=%0d want 0/0", out_valid, exp_q.size()); end
   endtask

   task automatic test_flush();
      do_reset();
      out_ready = 1'b0;
      push(64'h21, 5'd4, 2'b10); step();
      push(64'h22, 5'd5, 2'b10); step();
      flush = 1'b1; out_ready = 1'b1;
      push(64'h23, 5'd6, 2'b11); step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_state got valid=%b ready=%b want 0/1", out_valid, in_ready); end
      checks++; if (wb_control_out !== 2'b00) begin errors++; $display("FAIL flush_wb got %b want 00", wb_control_out); end
      checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_stall got %0d want 1", stall_cnt); end
      checks++; if (alu_out !== 64'h21) begin errors++; $display("FAIL flush_hold got %h want 21", alu_out); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %b want 0", out_valid); end
   endtask

   task automatic test_x0_squash();
      do_reset();
      out_ready = 1'b0;
      push(64'h31, 5'd0, 2'b11); step();
      in_valid = 1'b0;
      checks++; if (wb_control_out !== 2'b01) begin errors++; $display("FAIL x0_squash got %b want 01", wb_control_out); end
      checks++; if (ns_wb_control_out !== 2'b11) begin errors++; $display("FAIL x0_nosquash got %b want 11", ns_wb_control_out); end
      out_ready = 1'b1;
      push(64'h32, 5'd9, 2'b11); step();
      in_valid = 1'b0;
      checks++; if (wb_control_out !== 2'b11 || alu_out !== 64'h32) begin
         errors++; $display("FAIL x0_nonzero got wb=%b alu=%h want 11/32", wb_control_out, alu_out); end
   endtask

   task automatic test_stall_sat();
      do_reset();
      out_ready = 1'b0;
      push(64'h41, 5'd1, 2'b10); step();
      in_valid = 1'b0;
      for (int i = 0; i < 15; i++) step();
      checks++; if (c4_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach got %0d want 15", c4_stall_cnt); end
      for (int i = 0; i < 6; i++) step();
      checks++; if (c4_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", c4_stall_cnt); end
      checks++; if (stall_cnt !== 16'd21) begin errors++; $display("FAIL stall_wide got %0d want 21", stall_cnt); end
      checks++; if (alu_out !== 64'h41 || out_valid !== 1'b1) begin
         errors++; $display("FAIL stall_hold got %h/%b want 41/1", alu_out, out_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      push(64'h51, 5'd1, 2'b10); step();
      push(64'h52, 5'd2, 2'b10); step();
      reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
      push(64'h53, 5'd3, 2'b10); step();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'd0) begin
         errors++; $display("FAIL rmid_state got valid=%b ready=%b stall=%0d want 0/1/0", out_valid, in_ready, stall_cnt); end
      checks++; if (alu_out !== 64'd0 || dest_out !== 5'd0) begin
         errors++; $display("FAIL rmid_payload got %h/%0d want 0/0", alu_out, dest_out); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_discard got %b want 0", out_valid); end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_in = '0; mem_data_in = '0; dest_in = '0; wb_control_in = '0;
      test_reset();
      test_single();
      test_full_order();
      test_back_to_back();
      test_flush();
      test_x0_squash();
      test_stall_sat();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage_buf.md
MEM_WB_STAGE_BUF -- requirements
Module: mem_wb_stage_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of the ALU-result and memory-data payload fields.
REQ-002 Parameter REG_ID_WIDTH, default 5, width of the destination register id.
REQ-003 Parameter WB_CTRL_WIDTH, default 2, writeback control width; bit 1 = reg_write, bit 0 = mem_to_reg, upper bits opaque.
REQ-004 Parameter X0_SQUASH, default 1; when 1, reg_write is cleared for any entry captured with dest_in == 0.
REQ-005 Parameter CNT_WIDTH, default 16, width of the stall counter.
REQ-006 clk  input  1  clock; all state updates on posedge clk.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 flush  input  1  drop all buffered entries.
REQ-009 in_valid  input  1  upstream payload valid.
REQ-010 in_ready  output  1  buffer can accept this cycle.
REQ-011 alu_in  input  DATA_WIDTH  ALU result.
REQ-012 mem_data_in  input  DATA_WIDTH  memory load data.
REQ-013 dest_in  input  REG_ID_WIDTH  destination register id.
REQ-014 wb_control_in  input  WB_CTRL_WIDTH  writeback control.
REQ-015 out_valid  output  1  head entry valid.
REQ-016 out_ready  input  1  writeback stage consumes head this cycle.
REQ-017 alu_out, mem_data_out, dest_out, wb_control_out  output  same widths as inputs  head entry fields.
REQ-018 stall_cnt  output  CNT_WIDTH  cycles with out_valid=1 and out_ready=0.

Function
REQ-019 Storage SHALL be two payload registers: main (head) and skid; state SHALL be EMPTY, ONE or FULL.
REQ-020 accept = in_valid & in_ready & !flush; issue = out_valid & out_ready.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, derived from state only (no combinational path from out_ready).
REQ-022 out_valid SHALL be 1 in ONE and FULL; outputs SHALL present main register contents.
REQ-023 EMPTY: accept -> load main, go ONE; otherwise stay.
REQ-024 ONE: accept & !issue -> load skid, go FULL; issue & !accept -> EMPTY; accept & issue -> load main with incoming, stay ONE; neither -> stay.
REQ-025 FULL: issue -> main <= skid, go ONE; otherwise stay; no accept possible.
REQ-026 Ordering SHALL be strict FIFO; latency from accept to out_valid SHALL be exactly 1 cycle when buffer was EMPTY.
REQ-027 Sustained in_valid=1, out_ready=1 SHALL give one transfer per cycle with no bubbles.
REQ-028 flush SHALL have priority over all transitions: next state EMPTY, incoming payload dropped even if in_ready=1; outputs change in the following cycle.
REQ-029 When out_valid=0, wb_control_out SHALL be all zeros; alu_out, mem_data_out, dest_out hold last main contents.
REQ-030 With X0_SQUASH=1, an entry captured with dest_in==0 SHALL store wb_control bit 1 as 0; other bits unchanged.
REQ-031 stall_cnt SHALL increment each cycle out_valid & !out_ready, saturating at all-ones; unaffected by flush.
REQ-032 Payload registers SHALL load only on capture; no update while holding.

Reset
REQ-033 On reset: state EMPTY, in_ready=1 next cycle, out_valid=0, all payload fields 0, wb_control_out 0, stall_cnt 0.
REQ-034 reset SHALL dominate flush, in_valid and out_ready; reset mid-operation discards all entries.

Verification
REQ-035 Reset then in_valid=1, alu_in=0x11, dest_in=3, wb_control_in=2'b10 one cycle -> next cycle out_valid=1, alu_out=0x11, dest_out=3, wb_control_out=2'b10.
REQ-036 out_ready=0, push A, B -> FULL, in_ready=0, stall_cnt counts; push C held; out_ready=1 -> outputs A, B, C in order on consecutive cycles.
REQ-037 Streaming 100 entries with in_valid=out_ready=1 -> 100 transfers in 101 cycles, no drops, order preserved.
REQ-038 FULL with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, wb_control_out=0; stall_cnt unchanged.
REQ-039 Capture dest_in=0, wb_control_in=2'b11 with X0_SQUASH=1 -> wb_control_out=2'b01; with X0_SQUASH=0 -> 2'b11.
REQ-040 Hold out_ready=0 with out_valid=1 for 2^CNT_WIDTH+5 cycles (CNT_WIDTH=4) -> stall_cnt saturates at 15.
